// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pkg : shared types for the I/D cache memory-port arbiter          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    RESPOND = 3'd2,
    RELEASE = 3'd3,
    DRAIN   = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam int POL_FIXED = 0;
  localparam int POL_RR    = 1;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pick : combinational winner selection between I and D requesters  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module arb_pick
  import arb_pkg::*;
#(
  parameter int POLICY = POL_FIXED
) (
  input  logic       i_ireq,
  input  logic       i_dreq,
  input  arb_owner_t i_last_owner,
  input  logic       i_wait_sat,
  output arb_owner_t o_winner
);

  always_comb begin
    o_winner = OWN_D;
    if (i_ireq && !i_dreq) begin
      o_winner = OWN_I;
    end else if (i_ireq && i_dreq) begin
      if (POLICY == POL_RR) begin
        o_winner = (i_last_owner == OWN_I) ? OWN_D : OWN_I;
      end else begin
        // D normally wins a tie; a starved I-cache is forced through
        o_winner = i_wait_sat ? OWN_I : OWN_D;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem_arbiter : shares one cacheline memory port between I/D miss |
// | paths. Revision: 1.0                                                  |
// +----------------------------------------------------------------------+
module cache_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int POLICY   = POL_FIXED,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [LINE_W-1:0] i_rdata_o,
  output logic              i_resp_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              d_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  localparam int WCNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] c_max_wait = WCNT_W'(MAX_WAIT);

  arb_state_t        r_state;
  arb_state_t        w_next;
  arb_owner_t        r_owner;
  arb_owner_t        r_last_owner;
  arb_owner_t        w_winner;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              w_dreq;
  logic              w_start;
  logic              w_wait_sat;

  assign w_dreq     = d_read_i | d_write_i;
  assign w_start    = (r_state == IDLE) && (i_read_i || w_dreq);
  assign w_wait_sat = (r_wait_cnt == c_max_wait);

  arb_pick #(
    .POLICY(POLICY)
  ) u_pick (
    .i_ireq      (i_read_i),
    .i_dreq      (w_dreq),
    .i_last_owner(r_last_owner),
    .i_wait_sat  (w_wait_sat),
    .o_winner    (w_winner)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    i_resp_o    = 1'b0;
    d_resp_o    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = GRANT;
      end
      GRANT: begin
        mem_read_o  = !r_is_write;
        mem_write_o = r_is_write;
        if (mem_resp_i) w_next = RESPOND;
      end
      RESPOND: begin
        i_resp_o = (r_owner == OWN_I);
        d_resp_o = (r_owner == OWN_D);
        w_next   = RELEASE;
      end
      // The adaptor may hold its done flag; wait it out before re-arbitrating
      RELEASE: w_next = mem_resp_i ? DRAIN : IDLE;
      DRAIN: begin
        if (!mem_resp_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_owner      <= OWN_I;
      r_last_owner <= OWN_I;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_wait_cnt   <= '0;
    end else begin
      if (w_start) begin
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
        if (w_winner == OWN_I) begin
          r_addr     <= i_addr_i;
          r_is_write <= 1'b0;
          r_wait_cnt <= '0;
        end else begin
          r_addr     <= d_addr_i;
          r_is_write <= d_write_i;
          r_wdata    <= d_wdata_i;
          if (i_read_i && !w_wait_sat) r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end
      if ((r_state == GRANT) && mem_resp_i && !r_is_write) begin
        if (r_owner == OWN_I) r_i_rdata <= mem_rdata_i;
        else                  r_d_rdata <= mem_rdata_i;
      end
    end
  end

  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign i_rdata_o   = r_i_rdata;
  assign d_rdata_o   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_mem_arbiter : bench for fixed-priority and round-robin arbiter|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, mem_rdata;

  // index 0: fixed D-priority instance, index 1: round-robin instance
  logic [LW-1:0] o_irdata [2];
  logic [LW-1:0] o_drdata [2];
  logic [LW-1:0] o_mwdata [2];
  logic [AW-1:0] o_maddr  [2];
  logic          o_iresp  [2];
  logic          o_dresp  [2];
  logic          o_mr     [2];
  logic          o_mw     [2];

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .POLICY(0), .MAX_WAIT(MW)) u_fixed (
    .clk(clk), .reset_n(reset_n),
    .i_read_i(i_read), .i_addr_i(i_addr), .i_rdata_o(o_irdata[0]), .i_resp_o(o_iresp[0]),
    .d_read_i(d_read), .d_write_i(d_write), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(o_drdata[0]), .d_resp_o(o_dresp[0]),
    .mem_read_o(o_mr[0]), .mem_write_o(o_mw[0]), .mem_addr_o(o_maddr[0]),
    .mem_wdata_o(o_mwdata[0]), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
  );

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .POLICY(1), .MAX_WAIT(MW)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .i_read_i(i_read), .i_addr_i(i_addr), .i_rdata_o(o_irdata[1]), .i_resp_o(o_iresp[1]),
    .d_read_i(d_read), .d_write_i(d_write), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(o_drdata[1]), .d_resp_o(o_dresp[1]),
    .mem_read_o(o_mr[1]), .mem_write_o(o_mw[1]), .mem_addr_o(o_maddr[1]),
    .mem_wdata_o(o_mwdata[1]), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic       rst_n, ir, dr, dw, mresp;
    logic       emr, emw, eir, edr;
    logic [1:0] asel;   // 0: no addr check, 1: expect I addr, 2: expect D addr
    logic       isel;   // I rdata expected: 0 = zero, 1 = line A5
    logic       dsel;   // D rdata expected: 0 = zero, 1 = line A5
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  // ---------------- reference model state ----------------
  logic          m_pend  [2];
  logic          m_own   [2];   // 1 = D owns the transaction
  logic          m_wr    [2];
  logic          m_last  [2];   // 1 = D was last owner
  int            m_wait  [2];
  int            m_since [2];
  logic [AW-1:0] m_addr  [2];
  logic [LW-1:0] m_wd    [2];
  logic [LW-1:0] m_ird   [2];
  logic [LW-1:0] m_drd   [2];
  int            n_grants;

  function automatic logic pick(input int p, input logic ir, input logic dq);
    if (ir && !dq) return 1'b0;
    if (!ir)       return 1'b1;
    if (p == 1)    return !m_last[p];
    return (m_wait[p] == MW) ? 1'b0 : 1'b1;
  endfunction

  task automatic model_cycle(input int p);
    logic busy, ei, ed, dq, win;
    string tag;
    tag  = $sformatf("rnd%0d", p);
    busy = o_mr[p] | o_mw[p];
    dq   = d_read | d_write;
    ei   = 1'b0;
    ed   = 1'b0;
    if (m_pend[p]) begin
      if (mem_resp) begin
        if (m_own[p]) ed = 1'b1; else ei = 1'b1;
        if (!m_wr[p]) begin
          if (m_own[p]) m_drd[p] = mem_rdata; else m_ird[p] = mem_rdata;
        end
        m_pend[p]  = 1'b0;
        m_since[p] = 0;
      end
    end else if (busy) begin
      chk1({tag, "_grant_had_req"}, i_read | dq, 1'b1);
      chk1({tag, "_grant_gap"}, m_since[p] >= 2, 1'b1);
      win = pick(p, i_read, dq);
      if (win) begin
        if (i_read && m_wait[p] < MW) m_wait[p]++;
        m_wr[p]   = d_write;
        m_addr[p] = d_addr;
        m_wd[p]   = d_wdata;
      end else begin
        m_wait[p] = 0;
        m_wr[p]   = 1'b0;
        m_addr[p] = i_addr;
      end
      m_last[p] = win;
      m_own[p]  = win;
      m_pend[p] = 1'b1;
      n_grants++;
    end else if (m_since[p] < 100) begin
      m_since[p]++;
    end
    chk1({tag, "_i_resp"}, o_iresp[p], ei);
    chk1({tag, "_d_resp"}, o_dresp[p], ed);
    chkw({tag, "_i_rdata"}, o_irdata[p], m_ird[p]);
    chkw({tag, "_d_rdata"}, o_drdata[p], m_drd[p]);
    chk1({tag, "_busy"}, busy, m_pend[p]);
    if (m_pend[p]) begin
      chk1({tag, "_mem_read"}, o_mr[p], !m_wr[p]);
      chkw({tag, "_mem_addr"}, LW'(o_maddr[p]), LW'(m_addr[p]));
      if (m_wr[p]) chkw({tag, "_mem_wdata"}, o_mwdata[p], m_wd[p]);
    end
  endtask

  logic [LW-1:0] c_a5, c_c3;
  logic [9:0]    seq [2];
  int            cnt [2];

  initial begin
    c_a5 = {32{8'hA5}};
    c_c3 = {32{8'hC3}};
    reset_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    d_wdata = {8{32'hDEAD_BEEF}}; mem_rdata = c_a5;

    //            rst ir dr dw mr  emr emw eir edr  asel isel dsel
    tbl[0]  = 13'b0___0__0__0__0___0___0___0___0___00___0____0;
    tbl[1]  = 13'b1___1__0__0__0___1___0___0___0___01___0____0;
    tbl[2]  = 13'b1___1__0__0__0___1___0___0___0___01___0____0;
    tbl[3]  = 13'b1___1__0__0__1___0___0___1___0___00___1____0;
    tbl[4]  = 13'b1___0__0__0__0___0___0___0___0___00___1____0;
    tbl[5]  = 13'b1___0__0__0__0___0___0___0___0___00___1____0;
    tbl[6]  = 13'b1___1__0__1__0___0___1___0___0___10___1____0;
    tbl[7]  = 13'b1___1__0__1__1___0___0___0___1___00___1____0;
    tbl[8]  = 13'b1___1__0__0__0___0___0___0___0___00___1____0;
    tbl[9]  = 13'b1___1__0__0__0___0___0___0___0___00___1____0;
    tbl[10] = 13'b1___1__0__0__0___1___0___0___0___01___1____0;
    tbl[11] = 13'b1___1__0__0__1___0___0___1___0___00___1____0;
    tbl[12] = 13'b1___0__0__0__0___0___0___0___0___00___1____0;
    tbl[13] = 13'b1___0__0__0__0___0___0___0___0___00___1____0;
    tbl[14] = 13'b1___0__1__0__0___1___0___0___0___10___1____0;
    tbl[15] = 13'b1___0__1__0__1___0___0___0___1___00___1____1;
    tbl[16] = 13'b1___1__0__0__1___0___0___0___0___00___1____1;
    tbl[17] = 13'b1___1__0__0__1___0___0___0___0___00___1____1;
    tbl[18] = 13'b1___1__0__0__0___0___0___0___0___00___1____1;
    tbl[19] = 13'b1___1__0__0__0___1___0___0___0___01___1____1;
    tbl[20] = 13'b1___1__0__0__1___0___0___1___0___00___1____1;
    tbl[21] = 13'b1___0__0__0__0___0___0___0___0___00___1____1;
    tbl[22] = 13'b1___0__0__0__0___0___0___0___0___00___1____1;

    @(negedge clk);
    for (int r = 0; r < NV; r++) begin
      reset_n  = tbl[r].rst_n;
      i_read   = tbl[r].ir;
      d_read   = tbl[r].dr;
      d_write  = tbl[r].dw;
      mem_resp = tbl[r].mresp;
      step();
      for (int p = 0; p < 2; p++) begin
        chk1($sformatf("vec%0d_u%0d_mem_read", r, p), o_mr[p], tbl[r].emr);
        chk1($sformatf("vec%0d_u%0d_mem_write", r, p), o_mw[p], tbl[r].emw);
        chk1($sformatf("vec%0d_u%0d_i_resp", r, p), o_iresp[p], tbl[r].eir);
        chk1($sformatf("vec%0d_u%0d_d_resp", r, p), o_dresp[p], tbl[r].edr);
        chkw($sformatf("vec%0d_u%0d_i_rdata", r, p), o_irdata[p], tbl[r].isel ? c_a5 : '0);
        chkw($sformatf("vec%0d_u%0d_d_rdata", r, p), o_drdata[p], tbl[r].dsel ? c_a5 : '0);
        if (tbl[r].asel == 2'd1)
          chkw($sformatf("vec%0d_u%0d_mem_addr", r, p), LW'(o_maddr[p]), LW'(i_addr));
        if (tbl[r].asel == 2'd2)
          chkw($sformatf("vec%0d_u%0d_mem_addr", r, p), LW'(o_maddr[p]), LW'(d_addr));
        if (tbl[r].emw)
          chkw($sformatf("vec%0d_u%0d_mem_wdata", r, p), o_mwdata[p], d_wdata);
      end
    end

    // Both requesters held high for 10 transactions: starvation limit vs round-robin
    i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
    seq[0] = '0; seq[1] = '0; cnt[0] = 0; cnt[1] = 0;
    for (int c = 0; c < 200 && !(cnt[0] >= 10 && cnt[1] >= 10); c++) begin
      mem_resp = o_mr[0] | o_mw[0];
      step();
      for (int p = 0; p < 2; p++) begin
        if ((o_iresp[p] || o_dresp[p]) && cnt[p] < 10) begin
          seq[p][cnt[p]] = o_dresp[p];
          cnt[p]++;
        end
      end
    end
    chk1("tie_fixed_count10", cnt[0] == 10, 1'b1);
    chk1("tie_rr_count10", cnt[1] == 10, 1'b1);
    chkw("tie_fixed_order_DDDDIDDDDI", LW'(seq[0]), LW'(10'b01_1110_1111));
    chkw("tie_rr_order_DIDIDIDIDI", LW'(seq[1]), LW'(10'b01_0101_0101));

    // Reset while a transaction is in GRANT
    i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
    repeat (3) step();
    d_read = 1'b1; d_addr = 32'h0000_2040;
    step();
    chk1("rstgrant_pre_mem_read", o_mr[0], 1'b1);
    reset_n = 1'b0; mem_resp = 1'b1;
    step();
    for (int p = 0; p < 2; p++) begin
      chk1($sformatf("rstgrant_u%0d_mem_read", p), o_mr[p], 1'b0);
      chk1($sformatf("rstgrant_u%0d_mem_write", p), o_mw[p], 1'b0);
      chk1($sformatf("rstgrant_u%0d_resp", p), o_iresp[p] | o_dresp[p], 1'b0);
      chkw($sformatf("rstgrant_u%0d_i_rdata", p), o_irdata[p], '0);
      chkw($sformatf("rstgrant_u%0d_d_rdata", p), o_drdata[p], '0);
      chkw($sformatf("rstgrant_u%0d_mem_addr", p), LW'(o_maddr[p]), '0);
      chkw($sformatf("rstgrant_u%0d_mem_wdata", p), o_mwdata[p], '0);
    end
    reset_n = 1'b1; mem_resp = 1'b0; d_read = 1'b0;
    step();
    chk1("rstgrant_no_late_resp", o_iresp[0] | o_dresp[0] | o_iresp[1] | o_dresp[1], 1'b0);
    d_read = 1'b1; d_addr = 32'h0000_3000; mem_rdata = c_c3;
    step();
    chk1("rstgrant_fresh_mem_read", o_mr[0] & o_mr[1], 1'b1);
    chkw("rstgrant_fresh_addr", LW'(o_maddr[0]), LW'(32'h0000_3000));
    mem_resp = 1'b1;
    step();
    chk1("rstgrant_fresh_d_resp", o_dresp[0] & o_dresp[1], 1'b1);
    chk1("rstgrant_fresh_no_i_resp", o_iresp[0] | o_iresp[1], 1'b0);
    chkw("rstgrant_fresh_d_rdata", o_drdata[0], c_c3);
    chkw("rstgrant_fresh_i_rdata_kept", o_irdata[0], '0);
    d_read = 1'b0; mem_resp = 1'b0;
    step();

    // Randomized traffic against the transaction-level model
    reset_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step();
    reset_n = 1'b1;
    n_grants = 0;
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 1'b0; m_own[p] = 1'b0; m_wr[p] = 1'b0; m_last[p] = 1'b0;
      m_wait[p] = 0; m_since[p] = 10; m_addr[p] = '0; m_wd[p] = '0;
      m_ird[p] = '0; m_drd[p] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      i_read    = ($urandom_range(0, 2) != 0);
      d_read    = $urandom_range(0, 1) == 1;
      d_write   = ($urandom_range(0, 3) == 0);
      i_addr    = $urandom();
      d_addr    = $urandom();
      d_wdata   = {8{$urandom()}};
      mem_rdata = {8{$urandom()}};
      mem_resp  = m_pend[0] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      step();
      model_cycle(0);
      model_cycle(1);
    end
    chk1("random_grants_seen", n_grants > 200, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
